// File: rtl/a2d_arbiter.sv
// Round-robin arbiter sharing one A2D converter among three requesters.
// Ports: clk, rst_n (async active-low); req[2:0], req_chnnl[8:0] in;
//   gnt[2:0], rdy[2:0], res[11:0], busy, tmo_err out to requesters;
//   strt_cnv, chnnl[2:0] out to the A2D; cnv_cmplt, A2D_res[11:0] in.
module a2d_arbiter #(
    parameter logic [15:0] TMO = 16'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [8:0]  req_chnnl,
    output logic [2:0]  gnt,
    output logic [2:0]  rdy,
    output logic [11:0] res,
    output logic        busy,
    output logic        tmo_err,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] A2D_res
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  last;
    logic [1:0]  cur;
    logic [1:0]  c0;
    logic [1:0]  c1;
    logic [1:0]  win;
    logic [2:0]  win_oh;
    logic [2:0]  win_ch;
    logic [15:0] timer;
    logic        tmo_hit;

    function automatic logic [1:0] nxt(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Search order last+1, last+2, last (mod 3); the final
    // candidate is last itself, so it is the fall-through.
    assign c0 = nxt(last);
    assign c1 = nxt(c0);

    always_comb begin
        win = last;
        if (req[c0]) begin
            win = c0;
        end else if (req[c1]) begin
            win = c1;
        end
    end

    always_comb begin
        win_oh = 3'b000;
        win_ch = 3'b000;
        case (win)
            2'd0: begin
                win_oh = 3'b001;
                win_ch = req_chnnl[2:0];
            end
            2'd1: begin
                win_oh = 3'b010;
                win_ch = req_chnnl[5:3];
            end
            default: begin
                win_oh = 3'b100;
                win_ch = req_chnnl[8:6];
            end
        endcase
    end

    assign tmo_hit = (timer == TMO - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (|req) state_d = START;
            end
            START: state_d = WAIT;
            WAIT: begin
                if (cnv_cmplt || tmo_hit) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt     <= 3'b000;
            chnnl   <= 3'b000;
            cur     <= 2'd0;
            last    <= 2'd2;
            timer   <= 16'd0;
            res     <= 12'h000;
            tmo_err <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        gnt   <= win_oh;
                        chnnl <= win_ch;
                        cur   <= win;
                    end else begin
                        gnt <= 3'b000;
                    end
                end
                START: timer <= 16'd0;
                WAIT: begin
                    timer <= timer + 16'd1;
                    // A completion on the timeout cycle still counts.
                    if (cnv_cmplt) begin
                        res <= A2D_res;
                    end else if (tmo_hit) begin
                        res     <= 12'h000;
                        tmo_err <= 1'b1;
                    end
                end
                DONE: begin
                    last <= cur;
                    gnt  <= 3'b000;
                end
                default: gnt <= 3'b000;
            endcase
        end
    end

    // gnt still holds one-hot(cur) while in DONE.
    assign rdy      = (state_q == DONE) ? gnt : 3'b000;
    assign strt_cnv = (state_q == START);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_a2d_arbiter.sv
// Directed bench for a2d_arbiter with a result scoreboard.
// Ports: none; drives the DUT built with TMO = 16.
module tb_a2d_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [8:0]  req_chnnl;
    logic [2:0]  gnt;
    logic [2:0]  rdy;
    logic [11:0] res;
    logic        busy;
    logic        tmo_err;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] A2D_res;

    int ntests = 0;
    int nfail  = 0;

    typedef struct packed {
        logic [2:0]  r;
        logic [11:0] d;
    } exp_t;

    exp_t sb[$];

    a2d_arbiter #(.TMO(16'd16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_chnnl (req_chnnl),
        .gnt       (gnt),
        .rdy       (rdy),
        .res       (res),
        .busy      (busy),
        .tmo_err   (tmo_err),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .A2D_res   (A2D_res)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Enter DONE (bounded), compare against the scoreboard,
    // then confirm the return to IDLE.
    task automatic wait_rdy(input string tag, output int n);
        exp_t e;
        e = sb.pop_front();
        n = 0;
        tick();
        cnv_cmplt = 1'b0;
        while (rdy === 3'b000 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_rdy"}, 32'(rdy), 32'(e.r));
        chk({tag, "_res"}, 32'(res), 32'(e.d));
        tick();
        chk({tag, "_rdy_off"}, 32'(rdy), 0);
        chk({tag, "_gnt_off"}, 32'(gnt), 0);
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    // Called in an IDLE cycle with req already driven.
    task automatic run_conv(input string tag,
                            input logic [2:0] eg,
                            input logic [2:0] ech,
                            input logic [11:0] d,
                            input int dly,
                            input bit drop);
        int n;
        sb.push_back(exp_t'{r: eg, d: d});
        tick();
        chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
        chk({tag, "_chnnl"}, 32'(chnnl), 32'(ech));
        chk({tag, "_strt"}, 32'(strt_cnv), 1);
        tick();
        if (drop) req = 3'b000;
        chk({tag, "_strt_off"}, 32'(strt_cnv), 0);
        repeat (dly) tick();
        chk({tag, "_gnt_hold"}, 32'(gnt), 32'(eg));
        chk({tag, "_ch_hold"}, 32'(chnnl), 32'(ech));
        cnv_cmplt = 1'b1;
        A2D_res   = d;
        wait_rdy(tag, n);
        chk({tag, "_lat"}, 32'(n), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        req       = 3'b000;
        req_chnnl = 9'd0;
        cnv_cmplt = 1'b0;
        A2D_res   = 12'h000;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rdy", 32'(rdy), 0);
        chk("rst_res", 32'(res), 0);
        chk("rst_chnnl", 32'(chnnl), 0);
        chk("rst_tmo", 32'(tmo_err), 0);
        chk("rst_strt", 32'(strt_cnv), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick();

        // Single request, requester 1, channel 4
        req       = 3'b010;
        req_chnnl = {3'd0, 3'd4, 3'd0};
        run_conv("single", 3'b010, 3'd4, 12'hA5C, 0, 1'b0);
        req = 3'b000;

        // Stray completion in IDLE is ignored
        cnv_cmplt = 1'b1;
        A2D_res   = 12'h123;
        tick();
        cnv_cmplt = 1'b0;
        tick();
        chk("stray_res", 32'(res), 32'h A5C);
        chk("stray_rdy", 32'(rdy), 0);
        chk("stray_busy", 32'(busy), 0);

        // Contention: order 0,1,2,0 after reset
        do_reset();
        req       = 3'b111;
        req_chnnl = {3'd6, 3'd5, 3'd3};
        run_conv("rr0", 3'b001, 3'd3, 12'h111, 2, 1'b0);
        run_conv("rr1", 3'b010, 3'd5, 12'h222, 0, 1'b0);
        run_conv("rr2", 3'b100, 3'd6, 12'h333, 1, 1'b0);
        run_conv("rr3", 3'b001, 3'd3, 12'h444, 0, 1'b0);

        // Request dropped in WAIT still completes
        run_conv("drop", 3'b010, 3'd5, 12'h555, 3, 1'b1);
        chk("drop_req_low", 32'(req), 0);

        // Timeout after 16 WAIT cycles
        req       = 3'b100;
        req_chnnl = {3'd7, 3'd2, 3'd1};
        A2D_res   = 12'hFFF;
        sb.push_back(exp_t'{r: 3'b100, d: 12'h000});
        tick();
        chk("tmo_gnt", 32'(gnt), 32'(3'b100));
        chk("tmo_chnnl", 32'(chnnl), 7);
        repeat (16) tick();
        chk("tmo_not_early", 32'(rdy), 0);
        chk("tmo_busy", 32'(busy), 1);
        chk("tmo_flag_pre", 32'(tmo_err), 0);
        wait_rdy("tmo", n);
        chk("tmo_lat", 32'(n), 0);
        chk("tmo_flag", 32'(tmo_err), 1);

        // Good conversion afterwards keeps the sticky flag
        req = 3'b001;
        run_conv("post_tmo", 3'b001, 3'd1, 12'h7E1, 0, 1'b0);
        chk("tmo_sticky", 32'(tmo_err), 1);

        // Reset mid-WAIT
        req = 3'b010;
        tick();
        req = 3'b000;
        tick();
        tick();
        chk("mid_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_gnt", 32'(gnt), 0);
        chk("mid_rdy", 32'(rdy), 0);
        chk("mid_res", 32'(res), 0);
        chk("mid_chnnl", 32'(chnnl), 0);
        chk("mid_tmo", 32'(tmo_err), 0);
        chk("mid_strt", 32'(strt_cnv), 0);
        chk("mid_busy", 32'(busy), 0);
        tick();
        rst_n     = 1'b1;
        cnv_cmplt = 1'b1;
        A2D_res   = 12'hABC;
        tick();
        cnv_cmplt = 1'b0;
        tick();
        chk("mid_stray_res", 32'(res), 0);
        chk("mid_stray_rdy", 32'(rdy), 0);
        req = 3'b011;
        run_conv("mid_next", 3'b001, 3'd1, 12'h0F0, 0, 1'b0);
        req = 3'b000;

        // Completion on the timeout cycle wins
        req     = 3'b100;
        A2D_res = 12'h3C7;
        sb.push_back(exp_t'{r: 3'b100, d: 12'h3C7});
        tick();
        chk("bnd_gnt", 32'(gnt), 32'(3'b100));
        tick();
        repeat (15) tick();
        chk("bnd_rdy_pre", 32'(rdy), 0);
        cnv_cmplt = 1'b1;
        wait_rdy("bnd", n);
        chk("bnd_lat", 32'(n), 0);
        chk("bnd_tmo", 32'(tmo_err), 0);

        // Pointer wraps 2 -> 0
        req = 3'b111;
        run_conv("wrap", 3'b001, 3'd1, 12'h9D2, 0, 1'b0);
        req = 3'b000;

        chk("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/a2d_arbiter.md
A2D_ARBITER -- requirements
Module: a2d_arbiter

Interface
REQ-001 Parameter: TMO, default 16'd1024, WAIT-state cycles before a conversion is declared timed out.
REQ-002 Port: clk  input  1  system clock, all state on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  3  per-requester conversion request, level, bit i = requester i.
REQ-005 Port: req_chnnl  input  9  requested channels, [3i+2:3i] = requester i.
REQ-006 Port: gnt  output  3  one-hot grant, registered.
REQ-007 Port: rdy  output  3  one-cycle result-valid pulse to the granted requester.
REQ-008 Port: res  output  12  shared result register.
REQ-009 Port: busy  output  1  high whenever state != IDLE.
REQ-010 Port: tmo_err  output  1  sticky timeout flag.
REQ-011 Port: strt_cnv  output  1  one-cycle start pulse to the A2D.
REQ-012 Port: chnnl  output  3  A2D channel select, registered.
REQ-013 Port: cnv_cmplt  input  1  A2D conversion-done pulse.
REQ-014 Port: A2D_res  input  12  A2D conversion result.

Function
REQ-015 FSM states IDLE, START, WAIT, DONE, encoded in a 2-bit register.
REQ-016 IDLE with req != 0: select winner by round-robin, starting at (last+1) mod 3; register gnt = one-hot(winner), chnnl = req_chnnl[winner], cur = winner; next state START.
REQ-017 IDLE with req == 0: stay in IDLE; gnt = 0.
REQ-018 START: strt_cnv = 1 for exactly this cycle; clear 16-bit wait timer; next state WAIT.
REQ-019 WAIT: timer increments each cycle; chnnl and gnt held stable.
REQ-020 WAIT with cnv_cmplt = 1: res <= A2D_res; next state DONE.
REQ-021 WAIT with timer == TMO-1 and cnv_cmplt = 0: res <= 12'h000; tmo_err <= 1; next state DONE.
REQ-022 cnv_cmplt and timeout in the same cycle: cnv_cmplt wins; tmo_err is not set.
REQ-023 DONE: rdy[cur] = 1 for this cycle only; last <= cur; gnt cleared on the transition; next state IDLE.
REQ-024 cnv_cmplt in IDLE, START or DONE: ignored; res is unchanged.
REQ-025 A requester dropping req after grant does not abort the conversion; the conversion completes and rdy still pulses.
REQ-026 req still high in the IDLE cycle after rdy is a new request, arbitrated normally; a requester cannot win twice in a row while another requester is pending.
REQ-027 Latency: req in IDLE cycle 0 -> strt_cnv cycle 1 -> earliest cnv_cmplt cycle 2 -> rdy cycle 3.
REQ-028 res and chnnl hold their values after DONE until the next update.
REQ-029 tmo_err clears only on reset.
REQ-030 Round-robin pointer last wraps 2 -> 0.

Reset
REQ-031 rst_n low, asynchronously and at any state including mid-conversion: state = IDLE, gnt = 0, rdy = 0, res = 12'h000, chnnl = 3'b000, tmo_err = 0, strt_cnv = 0, busy = 0, timer = 0, last = 2 (requester 0 first).
REQ-032 A conversion interrupted by reset is lost; no rdy is issued for it.

Verification
REQ-033 Single request: req = 3'b010, req_chnnl[5:3] = 3'd4 -> gnt = 3'b010, chnnl = 4, one strt_cnv; cnv_cmplt with A2D_res = 12'hA5C -> res = 12'hA5C and rdy = 3'b010 for 1 cycle, 3 cycles after req with zero A2D delay.
REQ-034 Contention: req = 3'b111 held after reset -> grant order 0,1,2,0, one conversion each, no requester served twice consecutively.
REQ-035 Timeout: TMO = 16, cnv_cmplt held low -> DONE after 16 WAIT cycles, res = 12'h000, tmo_err = 1 and stays 1 through subsequent good conversions.
REQ-036 Boundary: cnv_cmplt asserted in the same cycle timer == TMO-1 -> res = A2D_res, tmo_err = 0.
REQ-037 Reset mid-WAIT: rst_n pulsed low -> all outputs at reset values immediately; later stray cnv_cmplt ignored; next req served by requester 0 priority.
REQ-038 Dropped request: req deasserted in WAIT -> conversion completes, rdy pulses, FSM returns to IDLE with gnt = 0.
